// File: rtl/key_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_conditioner_if
//  Bundles the raw key pins and the conditioned key outputs of key_conditioner.
//  Signal semantics: no valid/ready handshake exists on this bus. key_in is a
//  free-running asynchronous level. key_level is a registered level. key_press,
//  key_release and key_repeat are registered single-cycle strobes, and a
//  consumer must sample them on every clock edge.
//  Ports:
//   key_in      raw button pins (driven by the board/testbench side)
//   key_level   debounced state, 1 = pressed
//   key_press   1-cycle pulse on accepted press
//   key_release 1-cycle pulse on accepted release
//   key_repeat  1-cycle pulse per auto-repeat tick while held
//  Modports: master = pin/consumer side, slave = key_conditioner itself.
// -----------------------------------------------------------------------------
interface key_conditioner_if #(
  parameter int NUM_KEYS = 4
) ();
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat
  );
endinterface

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//  Push-button front end. Each key lane is independent and does the following:
//  it synchronises the pin with two flops, normalises polarity, debounces the
//  result, and then emits registered press/release pulses plus auto-repeat
//  pulses while the key is held.
//  Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset; release must be synchronous to clk
//   kif        key bus (slave modport): key_in in; key_level/press/release/repeat out
//   dbg_state  auto-repeat FSM state per lane, lane i at [2*i+1:2*i]
//              (0 RELEASED, 1 HOLD_DELAY, 2 HOLD_REPEAT)
// -----------------------------------------------------------------------------
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  key_conditioner_if.slave        kif,
  output logic [2*NUM_KEYS-1:0]   dbg_state
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  // Raw pin level of a released key; the synchroniser resets to it so that
  // leaving reset never looks like a press.
  localparam logic [NUM_KEYS-1:0] REL_RAW = {NUM_KEYS{(ACTIVE_LOW != 0)}};

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RR_LAST = RP_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_HOLD_DELAY  = 2'd1,
    ST_HOLD_REPEAT = 2'd2
  } rp_state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] key_s;

  logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];
  logic [DB_W-1:0]     db_cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] repeat_q, repeat_d;
  logic [NUM_KEYS-1:0] accept_press, accept_release;

  rp_state_e           state_q [NUM_KEYS];
  rp_state_e           state_d [NUM_KEYS];
  logic [RP_W-1:0]     rp_cnt_q [NUM_KEYS];
  logic [RP_W-1:0]     rp_cnt_d [NUM_KEYS];

  // Synchroniser and polarity normalisation (key_s: 1 = pressed).
  always_comb begin
    sync1_d = kif.key_in;
    sync2_d = sync1_q;
    key_s   = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples. Any agreeing sample restarts the count.
  always_comb begin
    level_d        = level_q;
    accept_press   = '0;
    accept_release = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (key_s[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        level_d[i]  = ~level_q[i];
        db_cnt_d[i] = '0;
        if (key_s[i]) accept_press[i]   = 1'b1;
        else          accept_release[i] = 1'b1;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
    press_d   = accept_press;
    release_d = accept_release;
  end

  // Auto-repeat FSM, next state and outputs. An accepted release takes
  // priority and suppresses any repeat tick that would land in the same cycle.
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i]  = state_q[i];
      rp_cnt_d[i] = rp_cnt_q[i];
      if (REPEAT_DELAY == 0) begin
        state_d[i]  = ST_RELEASED;
        rp_cnt_d[i] = '0;
      end else if (accept_release[i]) begin
        state_d[i]  = ST_RELEASED;
        rp_cnt_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_RELEASED: begin
            if (accept_press[i]) begin
              state_d[i]  = ST_HOLD_DELAY;
              rp_cnt_d[i] = '0;
            end
          end
          ST_HOLD_DELAY: begin
            if (rp_cnt_q[i] == RD_LAST) begin
              repeat_d[i] = 1'b1;
              rp_cnt_d[i] = '0;
              state_d[i]  = ST_HOLD_REPEAT;
            end else begin
              rp_cnt_d[i] = rp_cnt_q[i] + 1'b1;
            end
          end
          ST_HOLD_REPEAT: begin
            if (rp_cnt_q[i] == RR_LAST) begin
              repeat_d[i] = 1'b1;
              rp_cnt_d[i] = '0;
            end else begin
              rp_cnt_d[i] = rp_cnt_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i]  = ST_RELEASED;
            rp_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= REL_RAW;
      sync2_q   <= REL_RAW;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt_q[i] <= '0;
        rp_cnt_q[i] <= '0;
        state_q[i]  <= ST_RELEASED;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        rp_cnt_q[i] <= rp_cnt_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      dbg_state[2*i +: 2] = state_q[i];
    end
  end

  assign kif.key_level   = level_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
  assign kif.key_repeat  = repeat_q;

endmodule
